// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate cache controller
// sitting between a single CPU request port and a slower handshaked RAM port.
module cache_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic                  ram_ack,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  localparam int LINES     = 2 ** INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;

  typedef enum logic [2:0] {IDLE, LOOKUP, RAM_RD, RAM_WR, RESP} state_t;

  state_t state, state_next;

  logic [LINES-1:0]      valid;
  logic [TAG_WIDTH-1:0]  tags [LINES];
  logic [DATA_WIDTH-1:0] data [LINES];

  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   req_we;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   was_hit;
  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   hit;

  assign idx     = req_addr[INDEX_WIDTH-1:0];
  assign req_tag = req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
  assign hit     = valid[idx] && (tags[idx] == req_tag);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:           if (cpu_req) state_next = LOOKUP;
      LOOKUP: begin
        if (req_we)   state_next = RAM_WR;
        else if (hit) state_next = RESP;
        else          state_next = RAM_RD;
      end
      RAM_RD, RAM_WR: if (ram_ack) state_next = RESP;
      RESP:           state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  assign cpu_ready = (state == IDLE);
  assign cpu_done  = (state == RESP);
  assign ram_req   = (state == RAM_RD) || (state == RAM_WR);
  assign ram_we    = (state == RAM_WR);
  assign ram_addr  = req_addr;
  assign ram_wdata = req_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      cpu_rdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        LOOKUP: begin
          if (hit) begin
            if (hit_count != '1) hit_count <= hit_count + 16'd1;
            if (!req_we) cpu_rdata <= data[idx];
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 16'd1;
          end
        end
        RAM_RD: begin
          if (ram_ack) begin
            valid[idx] <= 1'b1;
            cpu_rdata  <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Unreset datapath; rst still gates array writes so an abandoned access leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            req_addr  <= cpu_addr;
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
          end
        end
        LOOKUP: was_hit <= hit;
        RAM_RD: begin
          if (ram_ack) begin
            data[idx] <= ram_rdata;
            tags[idx] <= req_tag;
          end
        end
        RAM_WR: if (ram_ack && was_hit) data[idx] <= req_wdata;
        default: ;
      endcase
    end
  end

endmodule
